// File: rtl/temp_stats_pkg.sv
// temp_stats_pkg
// Shared definitions for the windowed temperature statistics block:
//   TEMP_W       - width of one Fahrenheit reading
//   state_e      - sequencing states of the statistics engine
//   TREND_*      - encodings driven on the trend output
//   trend_of()   - classifies a new reading against the previous one
package temp_stats_pkg;

   localparam int TEMP_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [1:0] TREND_STEADY = 2'b00;
   localparam logic [1:0] TREND_RISE   = 2'b01;
   localparam logic [1:0] TREND_FALL   = 2'b10;

   // Equal readings count as steady so that a flat signal never toggles trend.
   function automatic logic [1:0] trend_of(input logic [TEMP_W-1:0] cur,
                                           input logic [TEMP_W-1:0] prev);
      if (cur > prev) begin
         return TREND_RISE;
      end else if (cur < prev) begin
         return TREND_FALL;
      end
      return TREND_STEADY;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider
// Restoring unsigned divider producing one quotient bit per clock.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - load dividend/divisor and begin (one-cycle pulse)
//   dividend  - DW-bit numerator
//   divisor   - VW-bit denominator (non-zero in normal use)
//   busy      - iterations in progress
//   done      - one-cycle pulse; quotient valid from this cycle until next start
//   quotient  - DW-bit truncated quotient
module seq_divider #(
   parameter int DW = 12,
   parameter int VW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient
);

   localparam int CW = $clog2(DW + 1);

   logic [DW-1:0] dq_q, dq_d;
   logic [VW-1:0] rem_q, rem_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [CW-1:0] iter_q, iter_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [VW:0]   shifted;

   // One restoring step per cycle: the dividend register shifts out its MSB into
   // the partial remainder and shifts the new quotient bit in at the bottom, so
   // after DW steps it holds the quotient. The remainder always stays below the
   // divisor, which is why VW bits are enough once the trial subtraction is done.
   always_comb begin
      dq_d    = dq_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      iter_d  = iter_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      shifted = '0;
      if (start) begin
         dq_d   = dividend;
         rem_d  = '0;
         dvs_d  = divisor;
         iter_d = CW'(DW);
         busy_d = 1'b1;
      end else if (busy_q) begin
         shifted = {rem_q, dq_q[DW-1]};
         if (shifted >= {1'b0, dvs_q}) begin
            rem_d = VW'(shifted - {1'b0, dvs_q});
            dq_d  = {dq_q[DW-2:0], 1'b1};
         end else begin
            rem_d = shifted[VW-1:0];
            dq_d  = {dq_q[DW-2:0], 1'b0};
         end
         iter_d = iter_q - CW'(1);
         if (iter_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Divider state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         dq_q   <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         iter_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         dq_q   <= dq_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         iter_q <= iter_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = dq_q;

endmodule

// File: rtl/temp_window_stats.sv
// temp_window_stats
// Samples an 8-bit Fahrenheit reading once per SAMPLE_DIV clocks into a circular
// history of DEPTH entries, then rescans the filled entries for min/max and
// divides the running sum by the fill count for a truncated average. Results are
// published together so consumers never see a mixed set.
// Ports:
//   clk, rst        - 100 MHz clock, synchronous active-high reset
//   new_temp        - current reading (unsigned degF)
//   new_temp_valid  - new_temp is usable; a tick with this low skips the sample
//   avg_temp        - truncated mean of filled entries
//   max_temp        - maximum of filled entries
//   min_temp        - minimum of filled entries
//   count           - filled entries, 0..DEPTH
//   stats_valid     - set by the first publication
//   trend           - 01 rising, 10 falling, 00 steady/unknown
// Build option: define TEMP_STATS_TREND_EN to enable the trend output;
// otherwise trend is tied to steady.
module temp_window_stats
   import temp_stats_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int SAMPLE_DIV = 100_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [TEMP_W-1:0]        new_temp,
   input  logic                     new_temp_valid,
   output logic [TEMP_W-1:0]        avg_temp,
   output logic [TEMP_W-1:0]        max_temp,
   output logic [TEMP_W-1:0]        min_temp,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     stats_valid,
   output logic [1:0]               trend
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int SUMW = TEMP_W + AW;
   localparam int TW   = $clog2(SAMPLE_DIV);

   // The tick spacing must leave room for the longest scan+divide sequence so a
   // tick never lands while the engine is busy.
   if (SAMPLE_DIV < 2 * DEPTH + 32) begin : g_bad_sample_div
      $error("temp_window_stats: SAMPLE_DIV must be at least 2*DEPTH+32");
   end
   if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("temp_window_stats: DEPTH must be a power of two in 2..256");
   end

   logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
   logic              tick;
   logic              accept;
   state_e            state_q, state_d;
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [SUMW-1:0]   sum_q, sum_d;
   logic [CW-1:0]     scan_q, scan_d;
   logic [TEMP_W-1:0] run_min_q, run_min_d;
   logic [TEMP_W-1:0] run_max_q, run_max_d;
   logic [TEMP_W-1:0] avg_q, avg_d;
   logic [TEMP_W-1:0] min_q, min_d;
   logic [TEMP_W-1:0] max_q, max_d;
   logic              valid_q, valid_d;
   logic [TEMP_W-1:0] hist_mem [DEPTH];
   logic [TEMP_W-1:0] rd_data_q;
   logic [TEMP_W-1:0] evict_val;
   logic              full;
   logic              div_start;
   logic              div_busy;
   logic              div_done;
   logic [SUMW-1:0]   div_quot;

   assign tick      = (tick_cnt_q == TW'(SAMPLE_DIV - 1));
   assign accept    = tick && (state_q == IDLE) && new_temp_valid;
   assign full      = (count_q == CW'(DEPTH));
   assign evict_val = full ? hist_mem[wptr_q] : '0;

   // Sample-side bookkeeping. Once the buffer is full the entry about to be
   // overwritten is subtracted from the sum, so the sum always matches the
   // window contents without ever re-adding the whole buffer.
   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      wptr_d     = wptr_q;
      count_d    = count_q;
      sum_d      = sum_q;
      if (accept) begin
         wptr_d  = wptr_q + AW'(1);
         count_d = full ? count_q : count_q + CW'(1);
         sum_d   = sum_q + SUMW'(new_temp) - SUMW'(evict_val);
      end
   end

   // Statistics engine. SCAN issues one registered read per cycle; the data for
   // address n arrives while scan_q is n+1, hence the extra SCAN cycle and the
   // seeding of min/max on scan_q == 1. Entries fill from index 0 after reset,
   // so indices 0..count-1 are exactly the filled entries. Published outputs
   // only change when leaving DONE.
   always_comb begin
      state_d   = state_q;
      scan_d    = scan_q;
      run_min_d = run_min_q;
      run_max_d = run_max_q;
      avg_d     = avg_q;
      min_d     = min_q;
      max_d     = max_q;
      valid_d   = valid_q;
      div_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SCAN;
               scan_d  = '0;
            end
         end
         SCAN: begin
            scan_d = scan_q + CW'(1);
            if (scan_q == CW'(1)) begin
               run_min_d = rd_data_q;
               run_max_d = rd_data_q;
            end else if (scan_q > CW'(1)) begin
               if (rd_data_q < run_min_q) begin
                  run_min_d = rd_data_q;
               end
               if (rd_data_q > run_max_q) begin
                  run_max_d = rd_data_q;
               end
            end
            if (scan_q == count_q) begin
               div_start = 1'b1;
               state_d   = DIV;
            end
         end
         DIV: begin
            if (div_done && !div_busy) begin
               state_d = DONE;
            end
         end
         DONE: begin
            avg_d   = (|div_quot[SUMW-1:TEMP_W]) ? '1 : div_quot[TEMP_W-1:0];
            min_d   = run_min_q;
            max_d   = run_max_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // History storage is left out of reset: count masks stale contents, and a
   // reset-free array with a registered read maps onto block RAM.
   always_ff @(posedge clk) begin
      if (accept) begin
         hist_mem[wptr_q] <= new_temp;
      end
      rd_data_q <= hist_mem[scan_q[AW-1:0]];
   end

   // Control and result registers; reset discards any in-flight computation.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
         state_q    <= IDLE;
         wptr_q     <= '0;
         count_q    <= '0;
         sum_q      <= '0;
         scan_q     <= '0;
         run_min_q  <= '0;
         run_max_q  <= '0;
         avg_q      <= '0;
         min_q      <= '0;
         max_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         count_q    <= count_d;
         sum_q      <= sum_d;
         scan_q     <= scan_d;
         run_min_q  <= run_min_d;
         run_max_q  <= run_max_d;
         avg_q      <= avg_d;
         min_q      <= min_d;
         max_q      <= max_d;
         valid_q    <= valid_d;
      end
   end

   seq_divider #(
      .DW(SUMW),
      .VW(CW)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (sum_q),
      .divisor  (count_q),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quot)
   );

`ifdef TEMP_STATS_TREND_EN
   logic [TEMP_W-1:0] prev_q, prev_d;
   logic              have_prev_q, have_prev_d;
   logic [1:0]        trend_q, trend_d;

   // Trend compares each accepted sample with the previous accepted one; the
   // first sample after reset has nothing to compare against and reads steady.
   always_comb begin
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      trend_d     = trend_q;
      if (accept) begin
         prev_d      = new_temp;
         have_prev_d = 1'b1;
         trend_d     = have_prev_q ? trend_of(new_temp, prev_q) : TREND_STEADY;
      end
   end

   // Trend state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         trend_q     <= TREND_STEADY;
      end else begin
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
         trend_q     <= trend_d;
      end
   end

   assign trend = trend_q;
`else
   assign trend = TREND_STEADY;
`endif

   assign avg_temp    = avg_q;
   assign max_temp    = max_q;
   assign min_temp    = min_q;
   assign count       = count_q;
   assign stats_valid = valid_q;

endmodule

// File: doc/temp_window_stats.md
# temp_window_stats

Windowed temperature statistics stage directly downstream of the Celsius-to-Fahrenheit converter. It samples the 8-bit Fahrenheit reading once per sample period and stores it in a circular history buffer of the last DEPTH samples. After each sample it recomputes min, max and truncated average over the filled entries, and feeds the display-selection logic and the heater/AC controller.

## Interface
- DEPTH, 16, history entries; power of 2, 2..256; AW = log2(DEPTH)
- SAMPLE_DIV, 100_000_000, clk cycles between sample ticks (1 s at 100 MHz); elaboration error if < 2*DEPTH + 32
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- new_temp  in  8  current temperature, °F, unsigned
- new_temp_valid  in  1  new_temp is usable this cycle
- avg_temp  out  8  truncated mean of filled entries
- max_temp  out  8  maximum of filled entries
- min_temp  out  8  minimum of filled entries
- count  out  AW+1  filled entries, 0..DEPTH
- stats_valid  out  1  high once the first statistics set is published
- trend  out  2  01 rising, 10 falling, 00 steady/unknown

## Operation
- Tick counter counts 0..SAMPLE_DIV-1 and wraps. Tick fires on wrap.
- On tick with FSM in IDLE and new_temp_valid=1, the sample is accepted:
  - write buffer[wptr]; wptr++ mod DEPTH
  - sum = sum + new_temp - (count==DEPTH ? buffer[wptr] : 0)
  - count++ saturating at DEPTH
- On tick with new_temp_valid=0: no state change; the sample is skipped.
- Sum width SUMW = 8 + AW; it never overflows.
- FSM: IDLE -> SCAN on accept.
  - SCAN reads entries 0..count-1, one per cycle. Reads are registered (BRAM-inferable), so SCAN lasts count+1 cycles. Running min/max seed from the first entry read.
  - SCAN -> DIV: restoring division sum/count, SUMW cycles, quotient truncated.
  - DIV -> DONE: one cycle. avg/min/max update together on the DONE edge and stats_valid sets.
  - DONE -> IDLE.
- Outputs hold between publications and never show partial results.
- Empty buffer (count=0): outputs stay at their reset values; no division occurs.
- Reset mid-operation: FSM returns to IDLE; the in-flight result is discarded; all registers are cleared. Buffer contents need not be cleared because count=0 masks them.

## Timing
- Reset values: avg_temp=0, max_temp=0, min_temp=0, count=0, stats_valid=0, trend=00; tick counter=0.
- count and trend update on the accept edge.
- Statistics latency: outputs visible count + SUMW + 3 cycles after the accept cycle, where count is the post-increment value. For DEPTH=16 at full buffer this is 31 cycles.
- The SAMPLE_DIV bound guarantees the FSM is in IDLE at every tick.

## Configuration
- TEMP_STATS_TREND_EN defined: a previous-sample register is loaded on each accept. trend compares the new sample with the previous accepted sample: greater -> 01, less -> 10, equal -> 00. trend is 00 on the first sample after reset.
- Undefined: no previous-sample register; trend is tied to 00. The port remains present.

## Structure
- Package temp_stats_pkg:
  - TEMP_W = 8
  - FSM state enum: IDLE, SCAN, DIV, DONE
  - trend encoding constants: TREND_STEADY, TREND_RISE, TREND_FALL
- Sub-module seq_divider: start/busy/done handshake, SUMW-bit dividend, (AW+1)-bit divisor, restoring, one quotient bit per cycle.

## Test plan
Bench uses SAMPLE_DIV=64, DEPTH=16, TEMP_STATS_TREND_EN defined.
- Reset held 3 cycles -> all outputs 0, stats_valid=0; no publication without valid samples.
- Accept 72, 74, 70 -> count=3, min=70, max=74, avg=72, trend=10 after the third sample; outputs change exactly count+15 cycles after each accept.
- Accept 16×68 then 80 -> count=16, sum=1100, avg=68 (truncated from 68.75), max=80, min=68, trend=01.
- Continue with 16×60 -> 80 is evicted: max=60, min=60, avg=60, count=16, trend=00.
- Hold new_temp_valid=0 across two ticks -> count, outputs and trend unchanged.
- Assert rst during SCAN -> outputs 0 on the next edge, no late publication. Next accept of 75 -> count=1, min=max=avg=75.
